xadc_drp_arbiter: RTL
=====================

Name: xadc_drp_arbiter

Overview:
Shares the single XADC DRP port between two requesters. The first is the automatic end-of-conversion readout, which reads the channel just converted. The second is a processor-issued DRP read/write used for configuration and status registers. The block sits between the xadc_fpro primitive wrapper and the slot core's register file, and emits tagged readout results for the channel registers. The automatic readout has strict priority; a software access is never preempted once issued.

Parameters:
TIMEOUT, 255, max cycles to wait for drdy after den before aborting (8-bit counter; legal 2..255)

Ports:
clk  in  1  system clock (also drives XADC dclk)
reset  in  1  asynchronous, active-high reset
eoc  in  1  XADC end-of-conversion pulse (1 cycle)
channel  in  5  XADC channel_out, valid with eoc
sw_req  in  1  software access request pulse
sw_we  in  1  1=DRP write, 0=DRP read; captured with sw_req
sw_addr  in  7  DRP address; captured with sw_req
sw_wdata  in  16  DRP write data; captured with sw_req
sw_busy  out  1  software access pending or in flight
sw_ack  out  1  1-cycle completion pulse
sw_rdata  out  16  read data, valid with sw_ack, held until next ack
sw_err  out  1  with sw_ack: access timed out
den  out  1  DRP enable (1-cycle pulse)
dwe  out  1  DRP write enable, valid with den
daddr  out  7  DRP address, valid with den
di  out  16  DRP write data, valid with den
drdy  in  1  DRP ready
do_in  in  16  DRP read data, valid with drdy
auto_valid  out  1  1-cycle pulse: auto readout complete
auto_channel  out  5  channel of auto_data
auto_data  out  16  converted value
overrun  out  1  sticky: eoc lost while auto request already pending
timeout_err  out  1  sticky: any DRP timeout
err_clr  in  1  clears overrun and timeout_err

Behaviour:
- Reset: every output is 0. State is IDLE, pending flags are clear, the counter is 0.
- Auto pending: eoc sets auto_pend and captures channel into auto_ch_q.
  - An eoc while auto_pend=1 overwrites auto_ch_q (newest wins) and sets overrun.
  - An eoc in the same cycle that auto_pend clears (issue) re-sets auto_pend with the new channel. This is not an overrun.
- SW pending: sw_req with sw_busy=0 captures we/addr/wdata and sets sw_busy. sw_req with sw_busy=1 is ignored; the in-flight access is unaffected.
- States are IDLE, AUTO_WAIT and SW_WAIT. All DRP outputs are registered.
- IDLE:
  - If auto_pend: den=1, dwe=0, daddr={2'b00,auto_ch_q}, then go to AUTO_WAIT and clear auto_pend.
  - Else if sw pending: den=1, dwe/daddr/di from the captured values, then go to SW_WAIT.
  - Latency: eoc at cycle t in an idle block puts den high at cycle t+2 (capture at t+1, issue at t+2).
- den is high for exactly one cycle per access. daddr/dwe/di hold their values until the next issue.
- WAIT states: the counter starts at 0 on issue and increments each cycle.
  - AUTO_WAIT with drdy: the next cycle has auto_valid=1, auto_data=do_in, auto_channel=issued channel, state IDLE.
  - SW_WAIT with drdy: the next cycle has sw_ack=1, sw_rdata=do_in (read) or unchanged (write), sw_err=0, sw_busy=0, state IDLE.
  - The counter reaching TIMEOUT without drdy returns the block to IDLE and sets timeout_err.
    - In AUTO_WAIT this sample is dropped and no auto_valid is issued.
    - In SW_WAIT: sw_ack=1, sw_err=1, sw_rdata unchanged, sw_busy=0.
- drdy in IDLE (spurious) is ignored.
- Next issue: the earliest next den is one cycle after returning to IDLE. Back-to-back DRP accesses therefore have at least one idle cycle between them.
- err_clr clears both sticky flags. If an error event occurs in the same cycle, the set wins.
- Reset mid-access aborts immediately. No ack or valid is produced; pending requests are discarded.

Test Plan:
- Auto read: eoc with channel=5'h13, drdy 3 cycles after den with do_in=16'hA5C0 -> den at t+2, daddr=7'h13, dwe=0; auto_valid once, auto_channel=5'h13, auto_data=16'hA5C0.
- SW write then read: sw_req we=1 addr=7'h41 wdata=16'h2000, drdy after 2 cycles -> den with dwe=1, di=16'h2000, sw_ack then sw_busy=0. Read of 7'h41 with do_in=16'h2000 -> sw_rdata=16'h2000.
- Priority: sw_req and eoc(ch 5'h1A) in the same cycle -> the auto access is issued first; the sw access is issued after auto_valid, with the gap required above. sw_busy stays 1 throughout.
- Overrun: three eocs (ch 0, 1, 3) during a 20-cycle sw access -> one auto read of ch 3 only, overrun=1. err_clr -> overrun=0.
- Timeout: TIMEOUT=8, sw read with drdy never asserted -> sw_ack with sw_err=1 exactly 8 cycles after den, timeout_err=1. A subsequent eoc is still serviced normally.
- Reset in SW_WAIT: assert reset -> all outputs 0. A late drdy after reset release produces no sw_ack.

Source files
------------

// File: rtl/xadc_drp_arbiter.sv
// Arbitrates the single XADC DRP port between end-of-conversion readout and
// processor-issued DRP accesses; auto readout wins, software is never preempted.
module xadc_drp_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eoc,
  input  logic [4:0]  channel,
  input  logic        sw_req,
  input  logic        sw_we,
  input  logic [6:0]  sw_addr,
  input  logic [15:0] sw_wdata,
  output logic        sw_busy,
  output logic        sw_ack,
  output logic [15:0] sw_rdata,
  output logic        sw_err,
  output logic        den,
  output logic        dwe,
  output logic [6:0]  daddr,
  output logic [15:0] di,
  input  logic        drdy,
  input  logic [15:0] do_in,
  output logic        auto_valid,
  output logic [4:0]  auto_channel,
  output logic [15:0] auto_data,
  output logic        overrun,
  output logic        timeout_err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    AUTO_WAIT = 2'd1,
    SW_WAIT   = 2'd2
  } state_t;

  // Last counter value that may still see drdy; one more cycle means timeout.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        auto_pend_q, auto_pend_d;
  logic [4:0]  auto_ch_q, auto_ch_d;
  logic        sw_busy_q, sw_busy_d;
  logic        sw_we_q, sw_we_d;
  logic [6:0]  sw_addr_q, sw_addr_d;
  logic [15:0] sw_wdata_q, sw_wdata_d;
  logic        sw_ack_q, sw_ack_d;
  logic [15:0] sw_rdata_q, sw_rdata_d;
  logic        sw_err_q, sw_err_d;
  logic        den_q, den_d;
  logic        dwe_q, dwe_d;
  logic [6:0]  daddr_q, daddr_d;
  logic [15:0] di_q, di_d;
  logic        auto_valid_q, auto_valid_d;
  logic [4:0]  auto_channel_q, auto_channel_d;
  logic [15:0] auto_data_q, auto_data_d;
  logic        overrun_q, overrun_d;
  logic        timeout_err_q, timeout_err_d;
  logic        auto_issue_s;
  logic        timeout_set_s;

  // Next-state: DRP sequencing, request capture and sticky error flags.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    auto_pend_d    = auto_pend_q;
    auto_ch_d      = auto_ch_q;
    sw_busy_d      = sw_busy_q;
    sw_we_d        = sw_we_q;
    sw_addr_d      = sw_addr_q;
    sw_wdata_d     = sw_wdata_q;
    sw_ack_d       = 1'b0;
    sw_rdata_d     = sw_rdata_q;
    sw_err_d       = 1'b0;
    den_d          = 1'b0;
    dwe_d          = dwe_q;
    daddr_d        = daddr_q;
    di_d           = di_q;
    auto_valid_d   = 1'b0;
    auto_channel_d = auto_channel_q;
    auto_data_d    = auto_data_q;
    overrun_d      = overrun_q;
    timeout_err_d  = timeout_err_q;
    auto_issue_s   = 1'b0;
    timeout_set_s  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (auto_pend_q) begin
          auto_issue_s = 1'b1;
          den_d        = 1'b1;
          dwe_d        = 1'b0;
          daddr_d      = {2'b00, auto_ch_q};
          state_d      = AUTO_WAIT;
        end else if (sw_busy_q) begin
          den_d   = 1'b1;
          dwe_d   = sw_we_q;
          daddr_d = sw_addr_q;
          di_d    = sw_wdata_q;
          state_d = SW_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      AUTO_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (drdy) begin
          auto_valid_d   = 1'b1;
          auto_data_d    = do_in;
          auto_channel_d = daddr_q[4:0];
          state_d        = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_set_s = 1'b1;
          state_d       = IDLE;
        end else begin
          state_d = AUTO_WAIT;
        end
      end
      SW_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (drdy) begin
          sw_ack_d  = 1'b1;
          sw_busy_d = 1'b0;
          state_d   = IDLE;
          if (!dwe_q) begin
            sw_rdata_d = do_in;
          end else begin
            sw_rdata_d = sw_rdata_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          sw_ack_d      = 1'b1;
          sw_err_d      = 1'b1;
          sw_busy_d     = 1'b0;
          timeout_set_s = 1'b1;
          state_d       = IDLE;
        end else begin
          state_d = SW_WAIT;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // A fresh eoc always re-arms; it only counts as lost if the old one was not issued.
    if (eoc) begin
      auto_pend_d = 1'b1;
      auto_ch_d   = channel;
    end else if (auto_issue_s) begin
      auto_pend_d = 1'b0;
    end else begin
      auto_pend_d = auto_pend_q;
    end

    if (sw_req && !sw_busy_q) begin
      sw_busy_d  = 1'b1;
      sw_we_d    = sw_we;
      sw_addr_d  = sw_addr;
      sw_wdata_d = sw_wdata;
    end else begin
      sw_we_d = sw_we_q;
    end

    if (eoc && auto_pend_q && !auto_issue_s) begin
      overrun_d = 1'b1;
    end else if (err_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    if (timeout_set_s) begin
      timeout_err_d = 1'b1;
    end else if (err_clr) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      auto_pend_q    <= 1'b0;
      auto_ch_q      <= 5'd0;
      sw_busy_q      <= 1'b0;
      sw_we_q        <= 1'b0;
      sw_addr_q      <= 7'd0;
      sw_wdata_q     <= 16'd0;
      sw_ack_q       <= 1'b0;
      sw_rdata_q     <= 16'd0;
      sw_err_q       <= 1'b0;
      den_q          <= 1'b0;
      dwe_q          <= 1'b0;
      daddr_q        <= 7'd0;
      di_q           <= 16'd0;
      auto_valid_q   <= 1'b0;
      auto_channel_q <= 5'd0;
      auto_data_q    <= 16'd0;
      overrun_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      auto_pend_q    <= auto_pend_d;
      auto_ch_q      <= auto_ch_d;
      sw_busy_q      <= sw_busy_d;
      sw_we_q        <= sw_we_d;
      sw_addr_q      <= sw_addr_d;
      sw_wdata_q     <= sw_wdata_d;
      sw_ack_q       <= sw_ack_d;
      sw_rdata_q     <= sw_rdata_d;
      sw_err_q       <= sw_err_d;
      den_q          <= den_d;
      dwe_q          <= dwe_d;
      daddr_q        <= daddr_d;
      di_q           <= di_d;
      auto_valid_q   <= auto_valid_d;
      auto_channel_q <= auto_channel_d;
      auto_data_q    <= auto_data_d;
      overrun_q      <= overrun_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign sw_busy      = sw_busy_q;
  assign sw_ack       = sw_ack_q;
  assign sw_rdata     = sw_rdata_q;
  assign sw_err       = sw_err_q;
  assign den          = den_q;
  assign dwe          = dwe_q;
  assign daddr        = daddr_q;
  assign di           = di_q;
  assign auto_valid   = auto_valid_q;
  assign auto_channel = auto_channel_q;
  assign auto_data    = auto_data_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_err_q;

endmodule
